// File: rtl/maf_window_filter_pkg.sv
// rtl/maf_window_filter_pkg.sv - shared constants, state type and width helper for the moving-average filter
//   MAF_BLOCK / MAF_SLIDE : values of the mode input
//   maf_state_e           : FILL (window filling) / RUN (sliding, window full)
//   maf_acc_width()       : accumulator width wide enough for W full-scale samples

package maf_pkg;

  localparam logic MAF_BLOCK = 1'b0;
  localparam logic MAF_SLIDE = 1'b1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } maf_state_e;

  function automatic int maf_acc_width(input int n, input int log2_w);
    return n + log2_w;
  endfunction

endpackage

// File: rtl/maf_window_filter_if.sv
// rtl/maf_window_filter_if.sv - sample/result bundle between the sample source and the filter
//   we, data_in, mode, clear : driven by the sample source (master)
//   data_out, valid_out      : driven by the filter (slave)

interface maf_window_filter_if #(
  parameter int N = 16
);

  logic         we;
  logic [N-1:0] data_in;
  logic         mode;
  logic         clear;
  logic [N-1:0] data_out;
  logic         valid_out;

  modport master (
    output we, data_in, mode, clear,
    input  data_out, valid_out
  );

  modport slave (
    input  we, data_in, mode, clear,
    output data_out, valid_out
  );

endinterface

// File: rtl/maf_window_filter_delay_line.sv
// rtl/maf_window_filter_delay_line.sv - W x N circular sample buffer with read-before-write at a shared pointer
//   clk, rst     : clock, asynchronous active-low reset (pointer only)
//   clear_i      : synchronous pointer flush, suppresses the write in the same cycle
//   wr_en_i      : write wr_data_i at the pointer and advance the pointer
//   wr_data_i    : sample to store
//   rd_data_o    : entry at the current pointer (the oldest sample once the buffer is full)

module maf_delay_line #(
  parameter int N      = 16,
  parameter int LOG2_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         wr_en_i,
  input  logic [N-1:0] wr_data_i,
  output logic [N-1:0] rd_data_o
);

  localparam int W = 1 << LOG2_W;

  logic [N-1:0]      mem [W];
  logic [LOG2_W-1:0] ptr_q, ptr_d;

  // W is a power of two, so the natural wrap of the pointer is the circular wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (wr_en_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are never read before being written, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clear_i) begin
      mem[ptr_q] <= wr_data_i;
    end
  end

  // Combinational read returns the entry about to be overwritten this cycle.
  assign rd_data_o = mem[ptr_q];

endmodule

// File: rtl/maf_window_filter.sv
// rtl/maf_window_filter.sv - power-of-two window moving-average filter, block or sliding mode
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of maf_window_filter_if (we/data_in/mode/clear in, data_out/valid_out out)
//   N        : sample and result width
//   LOG2_W   : log2 of the window depth (1..5)
//   SIGNED   : 1 = two's-complement samples, 0 = unsigned

module maf_window_filter
  import maf_pkg::*;
#(
  parameter int N      = 16,
  parameter int LOG2_W = 2,
  parameter int SIGNED = 0
) (
  input  logic clk,
  input  logic rst,
  maf_window_filter_if.slave bus
);

  localparam int A = maf_acc_width(N, LOG2_W);

  maf_state_e        state_q, state_d;
  logic [A-1:0]      acc_q, acc_d;
  logic [LOG2_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]      dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              mode_q;
  logic              mode_seen_q;

  logic              mode_change;
  logic              flush;
  logic              accept;
  logic [N-1:0]      oldest;
  logic [A-1:0]      new_ext;
  logic [A-1:0]      old_ext;
  logic [A-1:0]      acc_next;
  logic [N-1:0]      avg;

  // No previous mode exists in the first cycle after reset, so a held
  // mode level there is not a change and does not drop the first sample.
  assign mode_change = mode_seen_q && (bus.mode != mode_q);
  assign flush       = bus.clear || mode_change;
  assign accept      = bus.we && !flush;

  maf_delay_line #(
    .N      (N),
    .LOG2_W (LOG2_W)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (flush),
    .wr_en_i   (accept),
    .wr_data_i (bus.data_in),
    .rd_data_o (oldest)
  );

  // Sign or zero extension into the accumulator domain; all accumulator
  // arithmetic is then modulo 2^A, which is exact because the true window
  // sum always fits in A bits.
  assign new_ext = (SIGNED != 0) ? {{LOG2_W{bus.data_in[N-1]}}, bus.data_in}
                                 : {{LOG2_W{1'b0}}, bus.data_in};
  assign old_ext = (SIGNED != 0) ? {{LOG2_W{oldest[N-1]}}, oldest}
                                 : {{LOG2_W{1'b0}}, oldest};

  assign acc_next = (state_q == RUN) ? (acc_q + new_ext - old_ext)
                                     : (acc_q + new_ext);

  // Shift by LOG2_W then keep N bits: the bits dropped above N are exactly
  // the extension bits, so arithmetic and logical shifts give the same slice
  // and both round toward minus infinity.
  assign avg = acc_next[A-1:LOG2_W];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;

    if (flush) begin
      state_d = FILL;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (bus.we) begin
      case (state_q)
        FILL: begin
          if (&cnt_q) begin
            dout_d  = avg;
            valid_d = 1'b1;
            cnt_d   = '0;
            if (bus.mode == MAF_SLIDE) begin
              state_d = RUN;
              acc_d   = acc_next;
            end else begin
              acc_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_next;
          end
        end
        RUN: begin
          acc_d   = acc_next;
          dout_d  = avg;
          valid_d = 1'b1;
        end
        default: begin
          state_d = FILL;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      acc_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      mode_q      <= MAF_BLOCK;
      mode_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      mode_q      <= bus.mode;
      mode_seen_q <= 1'b1;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_maf_window_filter.sv
// tb/tb_maf_window_filter.sv - directed bench for maf_window_filter (unsigned and signed instances)

module tb_maf_window_filter;

  logic clk;
  logic rst;

  maf_window_filter_if #(.N(16)) bus_u ();
  maf_window_filter_if #(.N(16)) bus_s ();

  maf_window_filter #(.N(16), .LOG2_W(2), .SIGNED(0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (bus_u)
  );

  maf_window_filter #(.N(16), .LOG2_W(2), .SIGNED(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit                sgn;
    logic [3:0][15:0]  smp;
    logic [15:0]       exp;
  } vec_t;

  vec_t vecs [8];
  int   n_checks;
  int   n_errors;

  function automatic vec_t mk(input bit sgn, input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] s3,
                              input logic [15:0] e);
    vec_t v;
    v.sgn = sgn;
    v.smp = {s3, s2, s1, s0};
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then return just after the rising edge.
  task automatic step(input logic w, input logic [15:0] d, input logic clr, input logic m);
    @(negedge clk);
    bus_u.we = w; bus_u.data_in = d; bus_u.clear = clr; bus_u.mode = m;
    bus_s.we = w; bus_s.data_in = d; bus_s.clear = clr; bus_s.mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic sample4(input string name, input logic m, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                         input logic [15:0] exp);
    step(1'b1, a, 1'b0, m); check({name, "_v1"}, {15'd0, bus_u.valid_out}, 16'd0);
    step(1'b1, b, 1'b0, m); check({name, "_v2"}, {15'd0, bus_u.valid_out}, 16'd0);
    step(1'b1, c, 1'b0, m); check({name, "_v3"}, {15'd0, bus_u.valid_out}, 16'd0);
    step(1'b1, d, 1'b0, m); check({name, "_v4"}, {15'd0, bus_u.valid_out}, 16'd1);
    check({name, "_out"}, bus_u.data_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus_u.we = 1'b0; bus_u.data_in = '0; bus_u.clear = 1'b0; bus_u.mode = 1'b0;
    bus_s.we = 1'b0; bus_s.data_in = '0; bus_s.clear = 1'b0; bus_s.mode = 1'b0;

    vecs[0] = mk(1'b0, 16'd4,     16'd8,     16'd12,    16'd16,    16'd10);
    vecs[1] = mk(1'b0, 16'd1,     16'd1,     16'd1,     16'd1,     16'd1);
    vecs[2] = mk(1'b0, 16'd1,     16'd1,     16'd1,     16'd2,     16'd1);
    vecs[3] = mk(1'b1, 16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFE,  16'hFFFE);
    vecs[4] = mk(1'b0, 16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF);
    vecs[5] = mk(1'b1, 16'h8000,  16'h8000,  16'h8000,  16'h8000,  16'h8000);
    vecs[6] = mk(1'b0, 16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFE,  16'hFFFE);
    vecs[7] = mk(1'b1, 16'h0003,  16'hFFFC,  16'h0001,  16'hFFFF,  16'hFFFF);

    #12;
    check("reset_data_out", bus_u.data_out, 16'd0);
    check("reset_valid_out", {15'd0, bus_u.valid_out}, 16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Block-mode table: block mode restarts the window after every output.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, vecs[i].smp[k], 1'b0, 1'b0);
        if (k < 3) begin
          check($sformatf("blk%0d_nopulse%0d", i, k),
                {15'd0, (vecs[i].sgn ? bus_s.valid_out : bus_u.valid_out)}, 16'd0);
        end else begin
          check($sformatf("blk%0d_pulse", i),
                {15'd0, (vecs[i].sgn ? bus_s.valid_out : bus_u.valid_out)}, 16'd1);
          check($sformatf("blk%0d_avg", i),
                (vecs[i].sgn ? bus_s.data_out : bus_u.data_out), vecs[i].exp);
        end
      end
    end
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("blk_pulse_one_cycle", {15'd0, bus_u.valid_out}, 16'd0);
    check("blk_hold", bus_s.data_out, 16'hFFFF);

    // Sliding mode: the mode change itself flushes the block-mode state.
    step(1'b0, 16'd0, 1'b0, 1'b1);
    sample4("slide", 1'b1, 16'd4, 16'd8, 16'd12, 16'd16, 16'd10);
    step(1'b1, 16'd20, 1'b0, 1'b1);
    check("slide_v5", {15'd0, bus_u.valid_out}, 16'd1);
    check("slide_out5", bus_u.data_out, 16'd14);
    step(1'b1, 16'd24, 1'b0, 1'b1);
    check("slide_v6", {15'd0, bus_u.valid_out}, 16'd1);
    check("slide_out6", bus_u.data_out, 16'd18);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    check("slide_idle", {15'd0, bus_u.valid_out}, 16'd0);
    check("slide_hold", bus_u.data_out, 16'd18);

    // Block mode with random idle gaps between strobes.
    step(1'b0, 16'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      automatic int gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 16'hDEAD, 1'b0, 1'b0);
        check("gap_idle", {15'd0, bus_u.valid_out}, 16'd0);
      end
      step(1'b1, 16'(4 * (k + 1)), 1'b0, 1'b0);
      check($sformatf("gap_v%0d", k), {15'd0, bus_u.valid_out}, (k == 3) ? 16'd1 : 16'd0);
    end
    check("gap_out", bus_u.data_out, 16'd10);

    // Clear together with a strobe: clear wins, partial window is discarded too.
    step(1'b1, 16'd50, 1'b0, 1'b0);
    step(1'b1, 16'd100, 1'b1, 1'b0);
    check("clear_we_valid", {15'd0, bus_u.valid_out}, 16'd0);
    check("clear_keeps_out", bus_u.data_out, 16'd10);
    sample4("after_clear", 1'b0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd10);

    // Asynchronous reset in the middle of a sliding window.
    step(1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b1, 16'd7, 1'b0, 1'b1);
    step(1'b1, 16'd9, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_data_out", bus_u.data_out, 16'd0);
    check("async_rst_valid_out", {15'd0, bus_u.valid_out}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    sample4("post_rst", 1'b1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
    step(1'b1, 16'd6, 1'b0, 1'b1);
    check("post_rst_run_v", {15'd0, bus_u.valid_out}, 16'd1);
    check("post_rst_run_out", bus_u.data_out, 16'd3);

    // Mode switch from RUN to block: sample in the switching cycle is dropped.
    step(1'b1, 16'd99, 1'b0, 1'b0);
    check("modesw_valid", {15'd0, bus_u.valid_out}, 16'd0);
    check("modesw_hold", bus_u.data_out, 16'd3);
    sample4("modesw", 1'b0, 16'd0, 16'd0, 16'd4, 16'd4, 16'd2);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("modesw_end", {15'd0, bus_u.valid_out}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maf_window_filter.md
# maf_window_filter

Parametrised moving-average filter, next generation of the fixed 4-sample MAF. Window depth is a power of two. The block runs in two modes: block/decimating (one output per W samples) or sliding (one output per sample once the window is full). Signed or unsigned data. Sits between the ADC sample interface and the downstream detection logic; consumes one sample per `we` strobe and emits a registered average with a `valid_out` pulse.

## Interface
- `N`, 16: sample and output width in bits.
- `LOG2_W`, 2: log2 of window depth W; legal range 1..5 (W = 2..32).
- `SIGNED`, 0: 1 = two's-complement data with arithmetic shift; 0 = unsigned.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  sample strobe; `data_in` accepted on any rising edge with `we`=1.
- `data_in`  in  N  input sample.
- `mode`  in  1  0 = block/decimating, 1 = sliding.
- `clear`  in  1  synchronous flush of accumulator, delay line and counters.
- `data_out`  out  N  window average, registered, held between updates.
- `valid_out`  out  1  one-cycle pulse marking a new `data_out`.

## Operation
- Accumulator width is N+LOG2_W, so the sum of W full-scale samples never overflows. Sign-extend input when SIGNED=1.
- Average = acc_next >>> LOG2_W (arithmetic if SIGNED, logical otherwise). The result truncates toward −∞. The result is always representable in N bits.
- States: FILL, RUN.
  - FILL: sample counter cnt counts accepted samples.
  - Block mode: on the W-th accepted sample, output the average of those W samples (this sample included). Accumulator and cnt return to 0. State stays FILL.
  - Sliding mode: on the W-th accepted sample, output the average and go to RUN.
  - RUN (sliding only): each accepted sample computes acc ← acc + new − oldest, where oldest is read from the delay line. Every accepted sample produces an output.
- Delay line: W×N circular buffer. The write pointer advances on every accepted sample and wraps from W−1 to 0. Oldest = entry at the write pointer before the write. It is written in both modes but read only in RUN.
- `clear`=1: acc, cnt and pointer go to 0, state goes to FILL, `valid_out` goes to 0. `data_out` keeps its value. When `clear` and `we` are both high, clear wins and the sample is dropped.
- `mode` change without `clear`: internally treated as `clear` in the cycle the change is sampled. Any sample accepted in that cycle is dropped.
- `we`=0: no state change; `valid_out`=0.
- Gaps between strobes of any length do not affect results.

## Timing
- Reset (`rst`=0, asynchronous): `data_out`=0, `valid_out`=0, acc=0, cnt=0, pointer=0, state=FILL. Delay line contents need not be reset, because they are never read before being written.
- Latency: `data_out` and `valid_out` update on the same edge that accepts the qualifying sample. They are visible one cycle after `we` is presented.
- `valid_out` is high for exactly one cycle per output. Back-to-back strobes in RUN give back-to-back pulses.
- Throughput: one sample per cycle in both modes, no stall.
- Reset deassertion is synchronised externally. The first accepted sample is the first edge with `rst`=1 and `we`=1.

## Structure
- Package `maf_pkg` contains:
  - mode constants (MAF_BLOCK=0, MAF_SLIDE=1);
  - state enum (FILL, RUN);
  - accumulator-width constant/function (N+LOG2_W).
- Sub-module `maf_delay_line`:
  - parameters N, LOG2_W;
  - one write port and one read-before-write port at the shared pointer;
  - pointer owned by this sub-module, with a sync clear input.
- The top holds the FSM, counter, accumulator and output register.

## Test plan
All cases use N=16, LOG2_W=2.
- Block, unsigned: `we` with 4, 8, 12, 16 → single `valid_out` pulse with `data_out`=10 after the 4th sample. Then 1, 1, 1, 1 → 1.
- Sliding: 4, 8, 12, 16, 20, 24 → no pulse for the first 3 samples, then outputs 10, 14, 18 on consecutive accepted samples.
- Truncation and width:
  - unsigned block 1, 1, 1, 2 → 1;
  - SIGNED=1 block −1, −1, −1, −2 → −2 (0xFFFE);
  - unsigned 0xFFFF ×4 → 0xFFFF;
  - signed 0x8000 ×4 → 0x8000.
- Gaps and simultaneity:
  - 4, 8, 12, 16 with random `we`-low gaps → 10;
  - `clear`+`we` together with sample 100, then 4, 8, 12, 16 → 10 (100 dropped).
- Reset mid-operation: after 2 samples in sliding mode, pulse `rst` low mid-cycle → `data_out`=0 and `valid_out`=0 immediately. Then 2, 2, 2, 2 → first pulse on the 4th sample with 2.
- Mode switch: sliding in RUN, change `mode` to block → state flushed. The next 4 samples 0, 0, 4, 4 → 2, with no pulse before the 4th.
